// File: rtl/timestamp_pkg.sv
// -----------------------------------------------------------------------------
// timestamp_pkg
// Shared constants and helpers for the clk_osc_bufg timestamp block.
//   LONG_REG_WD_DEFAULT     : default counter / snapshot width
//   CLK_PERIOD_NS_DEFAULT   : default counter increment per clock (ns)
//   OSC_40MHZ_PERIOD_NS     : nominal period of the 40 MHz oscillator clock
//   TRIG_FIFO_DEPTH_DEFAULT : default trigger timestamp FIFO depth
//   log2_ceil()             : pointer width for the trigger FIFO
// No ports (package only).
// -----------------------------------------------------------------------------
package timestamp_pkg;

    localparam int LONG_REG_WD_DEFAULT     = 64;
    localparam int CLK_PERIOD_NS_DEFAULT   = 25;
    localparam int OSC_40MHZ_PERIOD_NS     = 25;
    localparam int TRIG_FIFO_DEPTH_DEFAULT = 4;

    // Smallest r such that 2**r >= value; used to size FIFO pointers.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timestamp_trig_fifo.sv
// -----------------------------------------------------------------------------
// timestamp_trig_fifo
// Show-ahead synchronous FIFO holding captured trigger timestamps.
// Full/empty come from a read/write pointer pair carrying one extra wrap bit.
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset (discards contents)
//   push         in   write push_data this cycle
//   push_data    in   WIDTH  value to store
//   pop          in   remove the head this cycle (ignored while empty)
//   overflow_clr in   clear the sticky overflow flag
//   head         out  WIDTH  registered head of FIFO, 0 when empty
//   empty        out  registered empty flag
//   overflow     out  sticky flag, set when a push was dropped
// -----------------------------------------------------------------------------
module timestamp_trig_fifo
    import timestamp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             overflow_clr,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = log2_ceil(DEPTH);

    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr_next;
    logic [AW:0]      wr_ptr_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_next;
    logic             is_empty;
    logic             is_full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    // Decide what actually happens this cycle. A pop frees a slot, so a push
    // into a full FIFO is still accepted when paired with a pop; a pop on an
    // empty FIFO is ignored even if a push arrives alongside it. The head
    // register is preloaded with whatever entry will be at the front next
    // cycle, which is the incoming data when it lands in the slot the read
    // pointer is about to point at.
    always_comb begin
        is_empty    = (rd_ptr == wr_ptr);
        is_full     = (rd_ptr[AW] != wr_ptr[AW]) &&
                      (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
        do_pop      = pop && !is_empty;
        do_push     = push && (!is_full || do_pop);
        drop        = push && !do_push;
        rd_ptr_next = rd_ptr + (AW+1)'(do_pop);
        wr_ptr_next = wr_ptr + (AW+1)'(do_push);
        head_next   = '0;
        if (rd_ptr_next != wr_ptr_next) begin
            if (do_push && (rd_ptr_next == wr_ptr)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    // Pointer, head, empty and overflow registers. When a drop and a clear
    // coincide the drop wins so firmware never loses the evidence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head     <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            head   <= head_next;
            empty  <= (rd_ptr_next == wr_ptr_next);
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/timestamp_osc_bufg.sv
// -----------------------------------------------------------------------------
// timestamp_osc_bufg
// Free-running nanosecond timestamp counter in the clk_osc_bufg domain with a
// load-on-request snapshot for the register list and optional capture of
// external trigger rising edges into a small FIFO.
// Build option: TIMESTAMP_TRIG_CAPTURE_EN compiles in the trigger synchronizer,
// edge detector, FIFO and overflow flag; without it the trigger outputs are
// tied to their idle values (head 0, empty 1, overflow 0).
// Ports:
//   clk_osc_bufg        in   40 MHz clock
//   reset_osc_bufg_n    in   synchronous active-low reset
//   i_timestamp_load    in   latch the counter into ov_timestamp
//   ov_timestamp        out  LONG_REG_WD  counter value at last load
//   i_trigger           in   asynchronous external trigger level
//   i_trig_rd           in   pop the trigger FIFO head
//   ov_trig_timestamp   out  LONG_REG_WD  FIFO head, 0 when empty
//   o_trig_empty        out  FIFO empty
//   o_trig_overflow     out  sticky dropped-trigger flag
//   i_trig_overflow_clr in   clear o_trig_overflow
// -----------------------------------------------------------------------------
module timestamp_osc_bufg
    import timestamp_pkg::*;
#(
    parameter int LONG_REG_WD     = LONG_REG_WD_DEFAULT,
    parameter int CLK_PERIOD_NS   = CLK_PERIOD_NS_DEFAULT,
    parameter int TRIG_FIFO_DEPTH = TRIG_FIFO_DEPTH_DEFAULT
) (
    input  logic                   clk_osc_bufg,
    input  logic                   reset_osc_bufg_n,
    input  logic                   i_timestamp_load,
    output logic [LONG_REG_WD-1:0] ov_timestamp,
    input  logic                   i_trigger,
    input  logic                   i_trig_rd,
    output logic [LONG_REG_WD-1:0] ov_trig_timestamp,
    output logic                   o_trig_empty,
    output logic                   o_trig_overflow,
    input  logic                   i_trig_overflow_clr
);

    localparam logic [LONG_REG_WD-1:0] INCREMENT =
        LONG_REG_WD'(unsigned'(CLK_PERIOD_NS));

    logic [LONG_REG_WD-1:0] counter;

    // The counter simply wraps on overflow. The snapshot follows the counter
    // on every cycle the load request is high, so a held request keeps
    // refreshing it; otherwise firmware sees a stable value.
    always_ff @(posedge clk_osc_bufg) begin
        if (!reset_osc_bufg_n) begin
            counter      <= '0;
            ov_timestamp <= '0;
        end else begin
            counter <= counter + INCREMENT;
            if (i_timestamp_load) begin
                ov_timestamp <= counter;
            end
        end
    end

`ifdef TIMESTAMP_TRIG_CAPTURE_EN

    logic [1:0] trig_sync;
    logic       trig_prev;
    logic       trig_edge;

    // Two flops tame the asynchronous trigger; a third remembers the previous
    // synchronized level so only low-to-high transitions are captured. Reset
    // clears all three, so a trigger already high at reset release is not
    // mistaken for an edge on the first cycle.
    always_ff @(posedge clk_osc_bufg) begin
        if (!reset_osc_bufg_n) begin
            trig_sync <= '0;
            trig_prev <= 1'b0;
        end else begin
            trig_sync <= {trig_sync[0], i_trigger};
            trig_prev <= trig_sync[1];
        end
    end

    assign trig_edge = trig_sync[1] && !trig_prev;

    timestamp_trig_fifo #(
        .WIDTH (LONG_REG_WD),
        .DEPTH (TRIG_FIFO_DEPTH)
    ) u_trig_fifo (
        .clk          (clk_osc_bufg),
        .rst_n        (reset_osc_bufg_n),
        .push         (trig_edge),
        .push_data    (counter),
        .pop          (i_trig_rd),
        .overflow_clr (i_trig_overflow_clr),
        .head         (ov_trig_timestamp),
        .empty        (o_trig_empty),
        .overflow     (o_trig_overflow)
    );

`else

    logic unused_trig_inputs;

    assign unused_trig_inputs = ^{i_trigger, i_trig_rd, i_trig_overflow_clr};
    assign ov_trig_timestamp  = '0;
    assign o_trig_empty       = 1'b1;
    assign o_trig_overflow    = 1'b0;

`endif

endmodule

// File: tb/tb_timestamp_osc_bufg.sv
// -----------------------------------------------------------------------------
// tb_timestamp_osc_bufg
// Self-checking bench for timestamp_osc_bufg. A behavioural model tracks the
// counter as plain arithmetic, the trigger level history per cycle, and the
// FIFO as a queue; outputs are compared every checked cycle on the falling
// clock edge. Trigger expectations follow whichever build option is active.
// -----------------------------------------------------------------------------
module tb_timestamp_osc_bufg;

    localparam int W = 64;
    localparam int P = 25;
    localparam int D = 4;

`ifdef TIMESTAMP_TRIG_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic         clk_osc_bufg        = 1'b0;
    logic         reset_osc_bufg_n    = 1'b0;
    logic         i_timestamp_load    = 1'b0;
    logic         i_trigger           = 1'b0;
    logic         i_trig_rd           = 1'b0;
    logic         i_trig_overflow_clr = 1'b0;
    logic [W-1:0] ov_timestamp;
    logic [W-1:0] ov_trig_timestamp;
    logic         o_trig_empty;
    logic         o_trig_overflow;

    timestamp_osc_bufg #(
        .LONG_REG_WD     (W),
        .CLK_PERIOD_NS   (P),
        .TRIG_FIFO_DEPTH (D)
    ) dut (
        .clk_osc_bufg        (clk_osc_bufg),
        .reset_osc_bufg_n    (reset_osc_bufg_n),
        .i_timestamp_load    (i_timestamp_load),
        .ov_timestamp        (ov_timestamp),
        .i_trigger           (i_trigger),
        .i_trig_rd           (i_trig_rd),
        .ov_trig_timestamp   (ov_trig_timestamp),
        .o_trig_empty        (o_trig_empty),
        .o_trig_overflow     (o_trig_overflow),
        .i_trig_overflow_clr (i_trig_overflow_clr)
    );

    always #5 clk_osc_bufg = ~clk_osc_bufg;

    // Reference model state
    logic [W-1:0] mCnt;
    logic [W-1:0] mTs;
    logic [W-1:0] mQ[$];
    bit           mOvf;
    bit   [3:0]   mLevels;

    int nVec = 0;
    int nErr = 0;

    // Drive one cycle of inputs (we sit at a falling edge), advance the model
    // to what the rising edge should produce, and return at the next falling
    // edge. mLevels[k] is the trigger level k cycles ago.
    task automatic applyStimulus(input bit rstN, input bit load, input bit trig,
                                 input bit rd, input bit clr);
        bit riseSeen;
        bit popOk;
        reset_osc_bufg_n    = rstN;
        i_timestamp_load    = load;
        i_trigger           = trig;
        i_trig_rd           = rd;
        i_trig_overflow_clr = clr;
        if (!rstN) begin
            mCnt    = '0;
            mTs     = '0;
            mQ.delete();
            mOvf    = 1'b0;
            mLevels = '0;
        end else begin
            mLevels  = {mLevels[2:0], trig};
            riseSeen = CAPTURE && mLevels[2] && !mLevels[3];
            popOk    = CAPTURE && rd && (mQ.size() > 0);
            if (popOk) begin
                void'(mQ.pop_front());
            end
            if (riseSeen) begin
                if (mQ.size() < D) begin
                    mQ.push_back(mCnt);
                end else begin
                    mOvf = 1'b1;
                end
            end
            if (!(riseSeen && mQ.size() == D && !popOk && mOvf) || !riseSeen) begin
                if (CAPTURE && clr && !(riseSeen && !popOk && mQ.size() == D)) begin
                    mOvf = 1'b0;
                end
            end
            if (load) begin
                mTs = mCnt;
            end
            mCnt = mCnt + W'(P);
        end
        @(posedge clk_osc_bufg);
        @(negedge clk_osc_bufg);
    endtask

    task automatic checkValue(input string tag, input logic [W-1:0] got,
                              input logic [W-1:0] exp);
        nVec++;
        assert (got === exp) else begin
            nErr++;
            $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [W-1:0] expHead;
        expHead = (mQ.size() > 0) ? mQ[0] : '0;
        checkValue({tag, ".ts"},    ov_timestamp,          mTs);
        checkValue({tag, ".head"},  ov_trig_timestamp,     expHead);
        checkValue({tag, ".empty"}, W'(o_trig_empty),      W'(mQ.size() == 0));
        checkValue({tag, ".ovf"},   W'(o_trig_overflow),   W'(mOvf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit level;
        int hold;
        @(negedge clk_osc_bufg);

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("reset");

        // Eight idle cycles then a load pulse captures 8*25
        idle(8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("load8");
        checkValue("load_200", ov_timestamp, 64'd200);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("hold");
        end

        // Held load re-latches every cycle
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("held_load");
        end

        // Counter wrap: preload 2^64-10, one cycle, then load gives 15
        force dut.counter = 64'hFFFF_FFFF_FFFF_FFF6;
        #1;
        release dut.counter;
        mCnt = 64'hFFFF_FFFF_FFFF_FFF6;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_idle");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_load");
        checkValue("wrap_15", ov_timestamp, 64'd15);

        // Single trigger rising in cycle 100 (counter 2500) seen at cycle 103
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("trig1");
        checkValue("trig1_head", ov_trig_timestamp, CAPTURE ? 64'd2550 : 64'd0);
        checkValue("trig1_empty", W'(o_trig_empty), W'(!CAPTURE));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("pop1");
        checkValue("pop1_empty", W'(o_trig_empty), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("pop_empty");
        idle(4);

        // Five triggers 10 cycles apart, no pops: fifth one is dropped
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            for (int i = 0; i < 7; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            checkOutput("five_trig");
        end
        checkValue("ovf_set", W'(o_trig_overflow), W'(CAPTURE));

        // Clear coinciding with a dropped push: flag stays set
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_vs_set");
        checkValue("clr_vs_set_ovf", W'(o_trig_overflow), W'(CAPTURE));
        idle(3);

        // Plain clear, then push and pop together while full
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("push_pop_full");
        checkValue("push_pop_ovf", W'(o_trig_overflow), 64'd0);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("drain");
        end

        // Randomized traffic with trigger pulses at least two cycles wide
        level = 1'b0;
        hold  = 2;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                level = !level;
                hold  = $urandom_range(2, 6);
            end
            hold--;
            applyStimulus(($urandom % 150) != 0, ($urandom % 8) == 0, level,
                          ($urandom % 5) == 0, ($urandom % 12) == 0);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/timestamp_osc_bufg.md
# timestamp_osc_bufg

Free-running 64-bit nanosecond timestamp counter in the 40 MHz clk_osc_bufg domain. It sits directly downstream of the osc_bufg register list. It consumes the one-cycle timestamp-load pulse from that list and feeds the latched value back to it as the read-only timestamp (0xd1..0xd4). It also captures timestamps of external trigger edges into a small FIFO for firmware readout.

## Interface
Parameters:
- LONG_REG_WD, 64, counter and snapshot width.
- CLK_PERIOD_NS, 25, counter increment per clock (ns per clk_osc_bufg cycle).
- TRIG_FIFO_DEPTH, 4, trigger timestamp FIFO entries; power of two, ≥2.

Ports:
- clk_osc_bufg  in  1  40 MHz clock; the only clock in the block.
- reset_osc_bufg_n  in  1  reset, synchronous, active-low.
- i_timestamp_load  in  1  latch request from the register list; normally a one-cycle pulse.
- ov_timestamp  out  LONG_REG_WD  counter value captured at the last load.
- i_trigger  in  1  asynchronous external trigger level.
- i_trig_rd  in  1  pop the FIFO head, one cycle.
- ov_trig_timestamp  out  LONG_REG_WD  FIFO head; 0 when empty.
- o_trig_empty  out  1  FIFO empty.
- o_trig_overflow  out  1  sticky flag: a trigger was dropped.
- i_trig_overflow_clr  in  1  clears o_trig_overflow.

## Operation
- Reset (reset_osc_bufg_n=0 at a clock edge) forces:
  - counter = 0 and ov_timestamp = 0
  - FIFO empty, o_trig_empty=1
  - ov_trig_timestamp = 0 and o_trig_overflow = 0
  - sync and edge flops = 0
- Counter: adds CLK_PERIOD_NS every cycle and wraps modulo 2^LONG_REG_WD with no flag. Width is LONG_REG_WD unsigned; the increment is zero-extended.
- Load: each cycle i_timestamp_load=1, ov_timestamp takes the current counter value. A load held high re-latches every cycle. Otherwise ov_timestamp holds.
- Trigger path:
  - i_trigger passes through a 2-flop synchronizer and then a rising-edge detector (sync[1]=1, previous=0).
  - On a detected edge, the current counter value is pushed into the FIFO.
  - Falling edges are ignored.
- FIFO (show-ahead):
  - ov_trig_timestamp shows the head and o_trig_empty reflects the occupancy.
  - Pop while empty: ignored.
  - Push while full with no pop: the new entry is dropped and o_trig_overflow is set.
  - Push and pop in the same cycle while full: both are accepted, with no overflow.
  - Push and pop in the same cycle while empty: push only; the pop is ignored.
- Overflow flag: i_trig_overflow_clr clears it. If a set and a clear happen in the same cycle, the set wins.
- Reset in mid-operation: pending synchronizer state and FIFO contents are discarded. No edge is detected on the first cycle after reset, even if i_trigger is already high.

## Timing
- All outputs are registered.
- Load latency: a pulse at cycle N gives ov_timestamp = counter(N), visible from N+1.
- Trigger latency:
  - i_trigger rises before edge E.
  - The edge is detected at E+2.
  - The pushed value is counter(E+2).
  - ov_trig_timestamp and o_trig_empty update at E+3.
- Pop: i_trig_rd at cycle N; the next head (or 0 and empty=1) appears at N+1.
- Minimum trigger high and low widths: 2 cycles each. Shorter pulses may be missed.

## Configuration
- TIMESTAMP_TRIG_CAPTURE_EN:
  - Defined: the synchronizer, edge detector, FIFO and overflow logic are compiled in.
  - Undefined:
    - The trigger path is removed.
    - ov_trig_timestamp is tied to 0, o_trig_empty to 1 and o_trig_overflow to 0.
    - i_trigger, i_trig_rd and i_trig_overflow_clr are ignored.
    - Counter and load behaviour are unchanged.

## Structure
- Shared package timestamp_pkg holds:
  - the default LONG_REG_WD and CLK_PERIOD_NS constants;
  - a log2 function for the FIFO pointer width;
  - the 40 MHz nominal period constant.
- One sub-module, timestamp_trig_fifo: the synchronous FIFO, parameterised by width and depth. It uses an extra-bit read/write pointer pair for full/empty detection and provides the overflow output.

## Test plan
- Reset release, 8 idle cycles, then a load pulse → ov_timestamp = 200 (8×25) one cycle after the pulse; no change without further loads.
- Preload the counter to 2^64−10 via a force, run one cycle, then load → value wraps to 15, with no glitch on other outputs.
- Single trigger rising edge at cycle 100 (counter = 2500) → at cycle 103 o_trig_empty = 0 and ov_trig_timestamp = 2550; pop → empty = 1 and head = 0 next cycle.
- Five triggers spaced 10 cycles apart with no pops → 4 entries held in order; the 5th is dropped and o_trig_overflow = 1; clear plus a simultaneous 6th-trigger push while full → flag remains 1.
- FIFO full, push and pop in the same cycle → occupancy stays 4, the oldest entry is removed, the new entry is at the tail, and the overflow flag stays 0.
- Build with the macro undefined, toggle i_trigger and i_trig_rd → outputs constant 0/1/0; load path passes the cycle-exact load check.
